mem_data_ctrl: RTL and testbench
================================

Name: mem_data_ctrl

Overview:
Byte-serial load/store sequencer between the multi-cycle core's LSU and a single-port, byte-wide data RAM of MEM_DEPTH bytes.
- Accepts one request at a time on a valid/ready handshake.
- Walks the 1/2/4 bytes of the access across consecutive cycles, little-endian.
- Assembles and sign/zero-extends load data.
- Returns a single-cycle response pulse; illegal or out-of-range requests get an error response instead.

Parameters:
MEM_DEPTH, 256, RAM size in bytes; power of two.
AW, $clog2(MEM_DEPTH), RAM address width; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset; synchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  controller can accept; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_code  in  3  load: funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU); store: 000 SB, 001 SH, 010 SW.
req_addr  in  32  byte address.
req_wdata  in  32  store data; byte k = req_wdata[8k+7:8k].
rsp_valid  out  1  one-cycle response pulse; no backpressure.
rsp_err  out  1  qualifies rsp_valid; access rejected.
rsp_rdata  out  32  load result; held until the next response.
mem_addr  out  AW  RAM byte address.
mem_we  out  1  RAM write strobe.
mem_wdata  out  8  RAM write byte.
mem_rdata  in  8  RAM read byte; registered, valid the cycle after mem_addr.

Behaviour:
- Reset: state IDLE; all registers cleared.
  - During rst: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - req_ready=1 in the first cycle after rst deasserts.
- Accept: req_valid & req_ready at a rising edge. Register addr, code, we and wdata; clear the byte counter k.
- Size N: code[1:0]=00→1, 01→2, 10→4.
- Error on any of:
  - code[1:0]=11;
  - store with code[2]=1;
  - load with code 110 or 111;
  - req_addr + N - 1 ≥ MEM_DEPTH, computed in 33 bits. No address wrap-around.
- States: IDLE, ERR, ISSUE, DRAIN, RESP.
- IDLE → ERR on accept of an illegal request; otherwise IDLE → ISSUE.
- ERR (1 cycle): rsp_valid=1, rsp_err=1, rsp_rdata unchanged, no RAM access; next state IDLE.
- ISSUE, N cycles, k = 0..N-1:
  - mem_addr = addr[AW-1:0] + k.
  - Store: mem_we=1, mem_wdata = wdata byte k.
  - Load: mem_we=0.
  - After k=N-1: store → RESP; load → DRAIN.
- Load capture: mem_rdata arriving in the cycle after byte k was issued is stored into assembly byte k.
  - Bytes 0..N-2 are captured during ISSUE.
  - Byte N-1 is captured in DRAIN (1 cycle, mem_we=0). DRAIN → RESP.
- RESP (1 cycle): rsp_valid=1, rsp_err=0; next state IDLE.
  - Load: rsp_rdata = assembled value extended per code.
    - LB: {{24{b0[7]}}, b0}
    - LH: {{16{b1[7]}}, b1, b0}
    - LW: {b3, b2, b1, b0}
    - LBU: {24'd0, b0}
    - LHU: {16'd0, b1, b0}
  - Store: rsp_rdata = 0.
- Latency, with cycle 0 = first cycle after the accept edge:
  - Error: rsp_valid in cycle 0.
  - Store: rsp_valid in cycle N.
  - Load: rsp_valid in cycle N+1.
  - req_ready returns high the cycle after rsp_valid.
- mem_we is high only in ISSUE for stores.
- mem_addr and mem_wdata are don't-care but held stable when mem_we=0.
- req_valid held high while busy is ignored, with no side effects.
- A request is accepted no earlier than the cycle after RESP/ERR; no overlap.
- Reset mid-operation: abort immediately.
  - Bytes already written stay written.
  - No rsp_valid is produced for the aborted request.

Test Plan:
- Preload RAM[0x10..0x13] = 80,7F,01,FE. LW 0x10 → mem_addr 0x10..0x13 in cycles 0–3; rsp_valid only in cycle 5; rsp_rdata = 0xFE017F80; rsp_err=0.
- On the same data: LB 0x10 → 0xFFFFFF80; LBU 0x10 → 0x00000080; LH 0x12 → 0xFFFFFE01; LHU 0x12 → 0x0000FE01; LH 0x11 → 0x0000017F (misaligned accepted). Each gets rsp_valid at cycle N+1.
- SH 0x20, wdata 0xAABBCCDD:
  - mem_we=1 in cycles 0–1 as (0x20, DD), (0x21, CC);
  - rsp_valid in cycle 2 with rsp_rdata = 0;
  - then LW 0x20 → low half 0xCCDD, upper bytes unchanged.
- Errors, each giving rsp_valid=1, rsp_err=1 in cycle 0, mem_we never high, rsp_rdata unchanged:
  - LW 0xFE (MEM_DEPTH=256);
  - SH 0xFF;
  - load code 011;
  - store code 100.
- SW 0x40, wdata 0x11223344, with rst asserted in cycle 1 → only RAM[0x40]=0x44 written; no rsp_valid; req_ready=0 during rst and 1 the cycle after.
- req_valid held high with back-to-back SB 0x50 then LBU 0x50:
  - second request accepted only the cycle after the first rsp_valid;
  - the load returns the stored byte, zero-extended.

Source files
------------

// File: rtl/mem_data_ctrl.sv
// mem_data_ctrl: byte-serial load/store sequencer between an LSU and a
// single-port, byte-wide data RAM.
//
// The controller takes one request at a time. It walks the 1, 2 or 4 bytes of
// the access over consecutive cycles in little-endian order. For loads it
// assembles the bytes and sign- or zero-extends the result. Every request ends
// in a one-cycle response pulse. Illegal or out-of-range requests get an error
// response and never touch the RAM.
//
// State | meaning
// IDLE  | ready for a request
// ERR   | one-cycle error response, no RAM access
// ISSUE | one RAM access per cycle, byte k = 0..N-1
// DRAIN | load only: capture the last read byte
// RESP  | one-cycle good response
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_we              1 = store, 0 = load
//   req_code            funct3 (size in [1:0], unsigned-load flag in [2])
//   req_addr            32-bit byte address
//   req_wdata           store data, byte k at [8k+7:8k]
//   rsp_valid/rsp_err   one-cycle response pulse and its error flag
//   rsp_rdata           load result, held until the next response
//   mem_addr/mem_we     RAM byte address and write strobe
//   mem_wdata/mem_rdata RAM write byte; read byte (valid one cycle after addr)
module mem_data_ctrl #(
  parameter  int MEM_DEPTH = 256,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_code,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [31:0]   rsp_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  typedef enum logic [2:0] {IDLE, ERR, ISSUE, DRAIN, RESP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [2:0]    code_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [1:0]    k_q;
  logic [31:0]   asm_q;
  logic [31:0]   rdata_q;

  logic [1:0]    req_last;
  logic [32:0]   req_end;
  logic          req_illegal;
  logic [1:0]    last_k;
  logic          cap_en;
  logic [1:0]    cap_idx;
  logic [31:0]   asm_next;
  logic [31:0]   load_ext;

  // Index of the last byte, for the incoming request and the active one.
  always_comb begin
    req_last = 2'd3;
    case (req_code[1:0])
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
  end

  always_comb begin
    last_k = 2'd3;
    case (code_q[1:0])
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  // The end address is computed in 33 bits so an access near 2^32 cannot wrap
  // back into range.
  assign req_end     = {1'b0, req_addr} + {31'd0, req_last};
  assign req_illegal = (req_code[1:0] == 2'b11)
                     | (req_we & req_code[2])
                     | (~req_we & req_code[2] & req_code[1])
                     | (req_end >= 33'(MEM_DEPTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_illegal ? ERR : ISSUE;
      ERR:     state_d = IDLE;
      ISSUE:   if (k_q == last_k) state_d = we_q ? RESP : DRAIN;
      DRAIN:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data lags the address by one cycle. During ISSUE the byte for k-1
  // arrives. In DRAIN the final byte arrives, and k is still held at N-1.
  always_comb begin
    cap_en  = 1'b0;
    cap_idx = k_q;
    if (state_q == ISSUE && !we_q && k_q != 2'd0) begin
      cap_en  = 1'b1;
      cap_idx = k_q - 2'd1;
    end else if (state_q == DRAIN) begin
      cap_en  = 1'b1;
    end
    asm_next = asm_q;
    if (cap_en) asm_next[{cap_idx, 3'b000} +: 8] = mem_rdata;
  end

  always_comb begin
    load_ext = asm_next;
    case (code_q)
      3'b000:  load_ext = {{24{asm_next[7]}}, asm_next[7:0]};
      3'b001:  load_ext = {{16{asm_next[15]}}, asm_next[15:0]};
      3'b100:  load_ext = {24'd0, asm_next[7:0]};
      3'b101:  load_ext = {16'd0, asm_next[15:0]};
      default: load_ext = asm_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      code_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      k_q     <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      // Only legal requests are latched. An error response therefore leaves
      // the RAM-side outputs untouched.
      if (state_q == IDLE && req_valid && !req_illegal) begin
        addr_q <= req_addr[AW-1:0];
        code_q <= req_code;
        we_q   <= req_we;
        k_q    <= '0;
        asm_q  <= '0;
        if (req_we) wdata_q <= req_wdata;
      end
      if (state_q == ISSUE && k_q != last_k) k_q <= k_q + 2'd1;
      if (cap_en) asm_q <= asm_next;
      if (state_q == DRAIN) rdata_q <= load_ext;
      if (state_q == ISSUE && we_q && k_q == last_k) rdata_q <= '0;
    end
  end

  // While rst is high, every output is forced to its idle value. This covers
  // the very first reset cycle and aborts an access mid-flight.
  assign req_ready = !rst && (state_q == IDLE);
  assign rsp_valid = !rst && (state_q == RESP || state_q == ERR);
  assign rsp_err   = !rst && (state_q == ERR);
  assign rsp_rdata = rst ? '0 : rdata_q;
  assign mem_we    = !rst && (state_q == ISSUE) && we_q;
  assign mem_addr  = rst ? '0 : addr_q + AW'(k_q);
  assign mem_wdata = rst ? '0 : wdata_q[{k_q, 3'b000} +: 8];

endmodule

// File: tb/tb_mem_data_ctrl.sv
module tb_mem_data_ctrl;
  localparam int MEM_DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_code = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  mem_data_ctrl #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_code(req_code), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] pre(input int i);
    case (i)
      'h10: return 8'h80;
      'h11: return 8'h7F;
      'h12: return 8'h01;
      'h13: return 8'hFE;
      'h20: return 8'h11;
      'h21: return 8'h22;
      'h22: return 8'h33;
      'h23: return 8'h44;
      'h40, 'h41, 'h42, 'h43: return 8'h00;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  // RAM environment: registered read, synchronous write
  logic [7:0] ram [MEM_DEPTH];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < MEM_DEPTH; i++) ram[i] <= pre(i);
      ram_init <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  // Transaction-level model: the expected outputs for any cycle follow from
  // the accept cycle, the access size and a shadow copy of the RAM.
  logic [7:0]  shadow [MEM_DEPTH];
  bit          sh_init = 1'b0;
  bit          busy = 1'b0;
  int          acc_cyc = 0;
  int          acc_count = 0;
  bit          m_we, m_err;
  int          m_n;
  logic [31:0] m_addr, m_wdata, m_exp;
  logic [31:0] m_last = '0;
  int          seen_cyc = -1;
  int          n_rsp = 0;
  logic [31:0] seen_rdata = '0;
  logic        seen_err = 1'b0;

  bit          e_rv, e_err, e_we, e_ready, c_addr, done;
  int          d;
  logic [7:0]  e_addr, e_wd;
  logic [7:0]  b [4];

  always @(negedge clk) begin
    if (!sh_init) begin
      for (int i = 0; i < MEM_DEPTH; i++) shadow[i] = pre(i);
      sh_init = 1'b1;
    end
    if (rst) begin
      chk("rst req_ready", req_ready, 0);
      chk("rst rsp_valid", rsp_valid, 0);
      chk("rst rsp_err", rsp_err, 0);
      chk("rst rsp_rdata", rsp_rdata, 0);
      chk("rst mem_we", mem_we, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      busy = 1'b0;
      m_last = '0;
    end else begin
      e_ready = !busy;
      e_rv = 0; e_err = 0; e_we = 0; c_addr = 0; done = 0;
      e_addr = '0; e_wd = '0;
      if (busy) begin
        d = cyc - acc_cyc - 1;
        if (m_err) begin
          e_rv = 1; e_err = 1; done = 1;
        end else if (d < m_n) begin
          c_addr = 1;
          e_addr = 8'(m_addr + 32'(d));
          if (m_we) begin
            e_we = 1;
            e_wd = 8'(m_wdata >> (8 * d));
            shadow[e_addr] = e_wd;
          end
        end else if (m_we || d == m_n + 1) begin
          e_rv = 1; done = 1;
          m_last = m_we ? 32'd0 : m_exp;
        end
      end
      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_err", rsp_err, e_err);
      chk("rsp_rdata", rsp_rdata, m_last);
      chk("mem_we", mem_we, e_we);
      if (c_addr) chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_wd);
      if (rsp_valid) begin
        seen_cyc = cyc; seen_rdata = rsp_rdata; seen_err = rsp_err; n_rsp++;
      end
      if (done) busy = 1'b0;
      if (e_ready && req_valid) begin
        m_we = req_we; m_addr = req_addr; m_wdata = req_wdata;
        m_n = (req_code[1:0] == 2'b00) ? 1 : (req_code[1:0] == 2'b01) ? 2 : 4;
        m_err = (req_code[1:0] == 2'b11) || (req_we && req_code[2])
             || (!req_we && req_code[2:1] == 2'b11)
             || ({32'd0, req_addr} + 64'(m_n) - 64'd1 >= 64'(MEM_DEPTH));
        if (!m_err && !m_we) begin
          m_exp = '0;
          for (int i = 0; i < m_n; i++) begin
            b[i] = shadow[int'(req_addr) + i];
            m_exp = m_exp + (32'(b[i]) << (8 * i));
          end
          if (!req_code[2] && m_n < 4 && b[m_n-1][7])
            m_exp = m_exp - (32'd1 << (8 * m_n));
        end
        acc_cyc = cyc;
        acc_count++;
        busy = 1'b1;
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] code, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit hold);
    int start;
    req_we = we; req_code = code; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    start = acc_count;
    for (int t = 0; t < 60 && acc_count == start; t++) begin
      @(posedge clk);
      #1;
    end
    chk("accept", acc_count != start, 1);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 60 && busy; t++) begin
      @(posedge clk);
      #1;
    end
    chk("idle", busy, 0);
  endtask

  task automatic lit(input string nm, input logic [31:0] er, input logic ee, input int lat);
    chk({nm, " rdata"}, seen_rdata, er);
    chk({nm, " err"}, seen_err, ee);
    chk({nm, " latency"}, seen_cyc - acc_cyc - 1, lat);
    chk({nm, " model"}, m_last, er);
  endtask

  initial begin
    int cnt, gap, mode;
    bit hold;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    send(0, 3'b010, 32'h10, 0, 0); wait_idle(); lit("LW 0x10", 32'hFE017F80, 0, 5);
    send(0, 3'b000, 32'h10, 0, 0); wait_idle(); lit("LB 0x10", 32'hFFFFFF80, 0, 2);
    send(0, 3'b100, 32'h10, 0, 0); wait_idle(); lit("LBU 0x10", 32'h00000080, 0, 2);
    send(0, 3'b001, 32'h12, 0, 0); wait_idle(); lit("LH 0x12", 32'hFFFFFE01, 0, 3);
    send(0, 3'b101, 32'h12, 0, 0); wait_idle(); lit("LHU 0x12", 32'h0000FE01, 0, 3);
    send(0, 3'b001, 32'h11, 0, 0); wait_idle(); lit("LH 0x11", 32'h0000017F, 0, 3);
    send(1, 3'b001, 32'h20, 32'hAABBCCDD, 0); wait_idle(); lit("SH 0x20", 32'h0, 0, 2);
    send(0, 3'b010, 32'h20, 0, 0); wait_idle(); lit("LW 0x20", 32'h4433CCDD, 0, 5);
    send(0, 3'b010, 32'hFE, 0, 0); wait_idle(); lit("LW 0xFE", 32'h4433CCDD, 1, 0);
    send(1, 3'b001, 32'hFF, 0, 0); wait_idle(); lit("SH 0xFF", 32'h4433CCDD, 1, 0);
    send(0, 3'b011, 32'h00, 0, 0); wait_idle(); lit("load 011", 32'h4433CCDD, 1, 0);
    send(1, 3'b100, 32'h00, 0, 0); wait_idle(); lit("store 100", 32'h4433CCDD, 1, 0);

    cnt = n_rsp;
    send(1, 3'b010, 32'h40, 32'h11223344, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("abort ram40", ram[8'h40], 8'h44);
    chk("abort ram41", ram[8'h41], 8'h00);
    chk("abort model40", shadow[8'h40], 8'h44);
    chk("abort no rsp", n_rsp - cnt, 0);

    send(1, 3'b000, 32'h50, 32'h5A5A5AC3, 1);
    send(0, 3'b100, 32'h50, 0, 0);
    chk("b2b accept gap", acc_cyc - seen_cyc, 1);
    wait_idle(); lit("LBU 0x50", 32'h000000C3, 0, 2);

    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 9);
      if (mode < 5)      a = $urandom_range(0, MEM_DEPTH - 1);
      else if (mode < 8) a = $urandom_range(MEM_DEPTH - 6, MEM_DEPTH - 1);
      else if (mode < 9) a = 32'hFFFFFFFF - $urandom_range(0, 3);
      else               a = $urandom;
      hold = ($urandom_range(0, 2) == 0);
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, hold);
      if ($urandom_range(0, 24) == 0) begin
        gap = $urandom_range(0, 5);
        repeat (gap) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end else if (!hold) begin
        wait_idle();
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    req_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
